div_rem_iterative_unit: RTL and testbench

//  Multi-cycle RV32M divide/remainder engine in the EX stage, beside the combinational ALU.

---
 rtl/div_rem_iterative_unit_pkg.sv | 28 ++
 rtl/div_restore_step.sv | 23 ++
 rtl/div_rem_iterative_unit.sv | 148 ++++++++++++++
 tb/tb_div_rem_iterative_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/div_rem_iterative_unit_pkg.sv
// Shared ALU opcode constants and operation decode for the iterative divide/remainder unit.
package div_rem_iterative_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] ALU_OP_DIV  = 5'b01000;
  localparam logic [4:0] ALU_OP_DIVU = 5'b01001;
  localparam logic [4:0] ALU_OP_REM  = 5'b01010;
  localparam logic [4:0] ALU_OP_REMU = 5'b01011;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } div_op_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) ||
           (op == ALU_OP_REM) || (op == ALU_OP_REMU);
  endfunction

  function automatic div_op_t decode_div_op(input logic [4:0] op);
    div_op_t d;
    d.is_signed = (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    d.is_rem    = (op == ALU_OP_REM) || (op == ALU_OP_REMU);
    return d;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration: shifts {rem,quo} left and subtracts divisor when it fits.
module div_restore_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next_c,
  output logic [W-1:0] quo_next_c
);

  logic [W:0] shifted_c;
  logic [W:0] diff_c;

  // Extra top bit keeps the shifted partial remainder and the borrow exact
  always_comb begin
    shifted_c  = {rem, quo[W-1]};
    diff_c     = shifted_c - {1'b0, divisor};
    quo_next_c = {quo[W-2:0], ~diff_c[W]};
    rem_next_c = diff_c[W] ? shifted_c[W-1:0] : diff_c[W-1:0];
  end

endmodule

// File: rtl/div_rem_iterative_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU engine: restoring division, one quotient bit per cycle.
module div_rem_iterative_unit
  import div_rem_iterative_unit_pkg::*;
#(
  parameter int unsigned XLEN         = div_rem_iterative_unit_pkg::XLEN,
  parameter bit          SPECIAL_FAST = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CNT_W-1:0] count, count_d;
  logic [XLEN-1:0] rem, rem_d, quo, quo_d, divisor, divisor_d;
  logic [XLEN-1:0] special_val, special_val_d, result_d;
  div_op_t         op, op_d;
  logic            neg_quo, neg_quo_d, neg_rem, neg_rem_d, special, special_d;

  div_op_t         dec_c;
  logic            s1_c, s2_c, div_zero_c, ovf_c;
  logic [XLEN-1:0] special_val_c, final_c;
  logic [XLEN-1:0] step_rem_c, step_quo_c;

  div_restore_step #(.W(XLEN)) u_step (
    .rem        (rem),
    .quo        (quo),
    .divisor    (divisor),
    .rem_next_c (step_rem_c),
    .quo_next_c (step_quo_c)
  );

  // Operand sign handling and special-case detection at accept time
  always_comb begin
    dec_c      = decode_div_op(opcode);
    s1_c       = dec_c.is_signed & data1[XLEN-1];
    s2_c       = dec_c.is_signed & data2[XLEN-1];
    div_zero_c = (data2 == '0);
    ovf_c      = dec_c.is_signed && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
    if (div_zero_c) special_val_c = dec_c.is_rem ? data1 : '1;
    else            special_val_c = dec_c.is_rem ? '0 : data1;
  end

  // Result of the final iteration with sign fix-up; special cases override the loop value
  always_comb begin
    if (special)         final_c = special_val;
    else if (op.is_rem)  final_c = neg_rem ? -step_rem_c : step_rem_c;
    else                 final_c = neg_quo ? -step_quo_c : step_quo_c;
  end

  always_comb begin
    state_d       = state;
    count_d       = count;
    rem_d         = rem;
    quo_d         = quo;
    divisor_d     = divisor;
    op_d          = op;
    neg_quo_d     = neg_quo;
    neg_rem_d     = neg_rem;
    special_d     = special;
    special_val_d = special_val;
    result_d      = result;
    unique case (state)
      IDLE: begin
        if (start && !flush && is_div_op(opcode)) begin
          rem_d         = '0;
          quo_d         = s1_c ? -data1 : data1;
          divisor_d     = s2_c ? -data2 : data2;
          op_d          = dec_c;
          neg_quo_d     = s1_c ^ s2_c;
          neg_rem_d     = s1_c;
          special_d     = div_zero_c | ovf_c;
          special_val_d = special_val_c;
          count_d       = '0;
          if (SPECIAL_FAST && (div_zero_c || ovf_c)) begin
            state_d  = FINISH;
            result_d = special_val_c;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem_c;
          quo_d   = step_quo_c;
          count_d = count + CNT_W'(1);
          if (count == CNT_W'(XLEN - 1)) begin
            state_d  = FINISH;
            result_d = final_c;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      op          <= '0;
      neg_quo     <= 1'b0;
      neg_rem     <= 1'b0;
      special     <= 1'b0;
      special_val <= '0;
      result      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      rem         <= rem_d;
      quo         <= quo_d;
      divisor     <= divisor_d;
      op          <= op_d;
      neg_quo     <= neg_quo_d;
      neg_rem     <= neg_rem_d;
      special     <= special_d;
      special_val <= special_val_d;
      result      <= result_d;
      busy        <= (state_d == CALC);
      done        <= (state_d == FINISH);
    end
  end

endmodule

// File: tb/tb_div_rem_iterative_unit.sv
// Directed self-checking bench for div_rem_iterative_unit (fast and full-loop special-case variants).
module tb_div_rem_iterative_unit;

  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_DIVU = 5'b01001;
  localparam logic [4:0] OP_REM  = 5'b01010;
  localparam logic [4:0] OP_REMU = 5'b01011;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] data1, data2;
  logic        flush;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] result_f, result_s;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prev_res;

  always #5 CLK = ~CLK;

  div_rem_iterative_unit #(.XLEN(32), .SPECIAL_FAST(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .opcode(opcode), .data1(data1),
    .data2(data2), .flush(flush), .busy(busy_f), .done(done_f), .result(result_f)
  );

  div_rem_iterative_unit #(.XLEN(32), .SPECIAL_FAST(1'b0)) dut_slow (
    .CLK(CLK), .RESET(RESET), .start(start), .opcode(opcode), .data1(data1),
    .data2(data2), .flush(flush), .busy(busy_s), .done(done_s), .result(result_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_f || busy_s || done_f || done_s) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check_eq("idle before start", 32'(n < 60), 32'd1);
  endtask

  // Issue one op and watch the selected DUT until done, counting edges from the accept edge
  task automatic run_op(input string tag, input bit slow, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int  edges = 0;
    int  busy_cycles = 0;
    bit  seen = 0;
    wait_idle();
    @(negedge CLK);
    start = 1'b1; opcode = op; data1 = a; data2 = b;
    while (!seen && edges < 100) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      start = 1'b0;
      data1 = ~a;
      data2 = b + 32'd3;
      if (slow ? busy_s : busy_f) busy_cycles++;
      if (slow ? done_s : done_f) seen = 1;
    end
    check_eq({tag, " done seen"}, 32'(seen), 32'd1);
    check_eq({tag, " latency"}, 32'(edges), 32'(exp_lat));
    check_eq({tag, " busy cycles"}, 32'(busy_cycles), 32'(exp_lat - 1));
    check_eq({tag, " result"}, slow ? result_s : result_f, exp);
    @(negedge CLK);
    check_eq({tag, " done pulse ends"}, 32'(slow ? done_s : done_f), 32'd0);
    check_eq({tag, " result held"}, slow ? result_s : result_f, exp);
    prev_res = exp;
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; opcode = '0; data1 = '0; data2 = '0; flush = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("reset busy", 32'(busy_f), 32'd0);
    check_eq("reset done", 32'(done_f), 32'd0);
    check_eq("reset result", result_f, 32'd0);
    check_eq("reset result slow", result_s, 32'd0);
    RESET = 1'b0;

    run_op("DIVU 100/7", 0, OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 0, OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIV -7/2", 0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", 0, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIV 7/-2", 0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("REM 7/-2", 0, OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("DIVU max/1", 0, OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("DIV 5/0 fast", 0, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0 fast", 0, OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf fast", 0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf fast", 0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("DIV 5/0 slow", 1, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("REM -5/0 slow", 1, OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 33);
    run_op("DIV ovf slow", 1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("REM ovf slow", 1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Rejected requests: invalid opcode, then start together with flush
    begin
      bit any_busy = 0;
      bit any_done = 0;
      wait_idle();
      @(negedge CLK);
      start = 1'b1; opcode = 5'b00000; data1 = 32'd9; data2 = 32'd3;
      @(negedge CLK);
      opcode = OP_DIVU; flush = 1'b1;
      @(negedge CLK);
      start = 1'b0; flush = 1'b0;
      for (int i = 0; i < 36; i++) begin
        if (busy_f) any_busy = 1;
        if (done_f) any_done = 1;
        @(negedge CLK);
      end
      check_eq("reject busy", 32'(any_busy), 32'd0);
      check_eq("reject done", 32'(any_done), 32'd0);
      check_eq("reject result", result_f, prev_res);
    end

    // Flush in the tenth CALC cycle
    begin
      bit any_done = 0;
      wait_idle();
      @(negedge CLK);
      start = 1'b1; opcode = OP_DIVU; data1 = 32'd100; data2 = 32'd7;
      @(negedge CLK);
      start = 1'b0;
      repeat (9) @(negedge CLK);
      check_eq("flush pre busy", 32'(busy_f), 32'd1);
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      check_eq("flush busy", 32'(busy_f), 32'd0);
      check_eq("flush done", 32'(done_f), 32'd0);
      for (int i = 0; i < 30; i++) begin
        if (done_f) any_done = 1;
        @(negedge CLK);
      end
      check_eq("flush no done", 32'(any_done), 32'd0);
      check_eq("flush result", result_f, prev_res);
    end
    run_op("REMU after flush", 0, OP_REMU, 32'd100, 32'd7, 32'd2, 33);

    // Asynchronous reset mid-CALC
    wait_idle();
    @(negedge CLK);
    start = 1'b1; opcode = OP_DIVU; data1 = 32'd1000; data2 = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    check_eq("pre-reset busy", 32'(busy_f), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check_eq("async reset busy", 32'(busy_f), 32'd0);
    check_eq("async reset done", 32'(done_f), 32'd0);
    check_eq("async reset result", result_f, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    run_op("DIVU 1000/3", 0, OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
